// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MIPS32 memory-access stage: opcodes, FSM
// encoding and byte-lane select constants.
package mem_defs;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } lsu_state_t;

  // Lane bit 3 carries bits 31:24 (big-endian byte 0).
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_H0   = 4'b1100;
  localparam logic [3:0] SEL_H1   = 4'b0011;
  localparam logic [3:0] SEL_W    = 4'b1111;

  function automatic logic [3:0] byte_sel(input logic [1:0] addr_lo);
    return SEL_B0 >> addr_lo;
  endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational access formatting: decode/alignment and store lanes for the
// incoming op, big-endian extraction and extension for the captured load.
module lsu_fmt
  import mem_defs::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  output logic        mem_op,
  output logic        load,
  output logic        misaligned,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  input  logic [7:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    mem_op     = 1'b0;
    load       = 1'b0;
    misaligned = 1'b0;
    sel        = SEL_NONE;
    wdata      = reg2;
    case (op)
      OP_LB, OP_LBU: begin
        mem_op = 1'b1;
        load   = 1'b1;
        sel    = byte_sel(addr_lo);
      end
      OP_LH, OP_LHU: begin
        mem_op     = 1'b1;
        load       = 1'b1;
        misaligned = addr_lo[0];
        sel        = addr_lo[1] ? SEL_H1 : SEL_H0;
      end
      OP_LW: begin
        mem_op     = 1'b1;
        load       = 1'b1;
        misaligned = |addr_lo;
        sel        = SEL_W;
      end
      OP_SB: begin
        mem_op = 1'b1;
        sel    = byte_sel(addr_lo);
        wdata  = {4{reg2[7:0]}};
      end
      OP_SH: begin
        mem_op     = 1'b1;
        misaligned = addr_lo[0];
        sel        = addr_lo[1] ? SEL_H1 : SEL_H0;
        wdata      = {2{reg2[15:0]}};
      end
      OP_SW: begin
        mem_op     = 1'b1;
        misaligned = |addr_lo;
        sel        = SEL_W;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata[31:24];
    case (ld_addr_lo)
      2'd0: ld_byte = rdata[31:24];
      2'd1: ld_byte = rdata[23:16];
      2'd2: ld_byte = rdata[15:8];
      2'd3: ld_byte = rdata[7:0];
      default: ;
    endcase
    ld_half = ld_addr_lo[1] ? rdata[15:0] : rdata[31:16];
    case (ld_op)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: passes non-memory ops through and runs one request/ack bus
// transaction per load/store, stalling the front of the pipe meanwhile.
module mem_lsu
  import mem_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        mem_whilo_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        stallreq,
  output logic        addr_err,
  output logic        bus_err,
  output logic [1:0]  lsu_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0] ld_buf_q;
  logic        req_q, we_q, timed_out_q, bus_err_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic [7:0]  op_q;
  logic [1:0]  alo_q;

  logic        acc_mem, acc_load, acc_misaligned;
  logic [3:0]  acc_sel;
  logic [31:0] acc_wdata, ld_data;
  logic        go, timeout_hit;

  lsu_fmt u_fmt (
    .op         (mem_aluop_i),
    .addr_lo    (mem_addr_i[1:0]),
    .reg2       (mem_reg2_i),
    .mem_op     (acc_mem),
    .load       (acc_load),
    .misaligned (acc_misaligned),
    .sel        (acc_sel),
    .wdata      (acc_wdata),
    .ld_op      (op_q),
    .ld_addr_lo (alo_q),
    .rdata      (dbus_rdata),
    .ld_data    (ld_data)
  );

  assign go          = (state_q == ST_IDLE) && acc_mem && !acc_misaligned;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (go) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (dbus_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ld_buf_q    <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= SEL_NONE;
      op_q        <= '0;
      alo_q       <= '0;
      timed_out_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            req_q       <= 1'b1;
            we_q        <= !acc_load;
            addr_q      <= {mem_addr_i[31:2], 2'b00};
            sel_q       <= acc_sel;
            wdata_q     <= acc_wdata;
            op_q        <= mem_aluop_i;
            alo_q       <= mem_addr_i[1:0];
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
          end
        end
        ST_WAIT_ACK: begin
          cnt_q <= cnt_q + CW'(1);
          if (dbus_ack) begin
            ld_buf_q <= ld_data;
            req_q    <= 1'b0;
          end else if (timeout_hit) begin
            // bus_err is registered, so it lands in the DONE cycle
            req_q       <= 1'b0;
            timed_out_q <= 1'b1;
            bus_err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_wd    = mem_wd_i;
    mem_wreg  = mem_wreg_i;
    mem_wdata = mem_wdata_i;
    mem_hi    = mem_hi_i;
    mem_lo    = mem_lo_i;
    mem_whilo = mem_whilo_i;
    stallreq  = 1'b0;
    addr_err  = 1'b0;
    if (rst) begin
      mem_wd    = NOP_REG_ADDR;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
      mem_hi    = '0;
      mem_lo    = '0;
      mem_whilo = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_mem) begin
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
            if (acc_misaligned) addr_err = 1'b1;
            else                stallreq = 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
          stallreq  = 1'b1;
        end
        ST_DONE: begin
          mem_wreg  = mem_wreg_i && !timed_out_q;
          mem_whilo = 1'b0;
          if (!we_q) mem_wdata = ld_buf_q;
        end
        default: ;
      endcase
    end
  end

  // Request drops in the reset cycle itself rather than one edge later
  assign dbus_req   = req_q && !rst;
  assign dbus_we    = we_q && !rst;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;
  assign bus_err    = bus_err_q && !rst;
  assign lsu_state  = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios followed by randomized accesses
// checked against an arithmetic model of lanes, alignment and extension.
module tb_mem_lsu;

  localparam int TO = 4;

  localparam logic [7:0] T_LB  = 8'hE0;
  localparam logic [7:0] T_LBU = 8'hE4;
  localparam logic [7:0] T_LH  = 8'hE1;
  localparam logic [7:0] T_LHU = 8'hE5;
  localparam logic [7:0] T_LW  = 8'hE3;
  localparam logic [7:0] T_SB  = 8'hE8;
  localparam logic [7:0] T_SH  = 8'hE9;
  localparam logic [7:0] T_SW  = 8'hEB;
  localparam logic [7:0] T_ADD = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i, mem_hi_i, mem_lo_i;
  logic        mem_whilo_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i, mem_reg2_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic        dbus_ack;
  logic        stallreq, addr_err, bus_err;
  logic [1:0]  lsu_state;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_whilo_i(mem_whilo_i),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .stallreq(stallreq), .addr_err(addr_err),
    .bus_err(bus_err), .lsu_state(lsu_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [7:0] op);
    if (op == T_LB || op == T_LBU || op == T_SB) return 1;
    if (op == T_LH || op == T_LHU || op == T_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_load(input logic [7:0] op);
    return op == T_LB || op == T_LBU || op == T_LH || op == T_LHU || op == T_LW;
  endfunction

  function automatic bit is_misaligned(input logic [7:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % acc_size(op)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
    int sz;
    int v;
    sz = acc_size(op);
    v = ((1 << sz) - 1) << (4 - sz - int'(addr[1:0]));
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] reg2);
    case (acc_size(op))
      1:       return {24'd0, reg2[7:0]} * 32'h01010101;
      2:       return {16'd0, reg2[15:0]} * 32'h00010001;
      default: return reg2;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int sz;
    logic [31:0] v, mask;
    sz = acc_size(op);
    if (sz == 4) return rdata;
    v = rdata >> (8 * (4 - sz - int'(addr[1:0])));
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if ((op == T_LB || op == T_LH) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_inst(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] alu);
    mem_aluop_i = op;
    mem_addr_i  = addr;
    mem_reg2_i  = reg2;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = alu;
    mem_hi_i    = $urandom;
    mem_lo_i    = $urandom;
    mem_whilo_i = 1'($urandom_range(0, 1));
  endtask

  // One complete memory instruction; caller pushes the DONE-cycle wdata
  // expectation onto exp_q unless the access is misaligned.
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] alu,
                           input logic [31:0] rdata, input int ack_after);
    bit timed;
    logic [31:0] exp_dw;
    @(negedge clk);
    set_inst(op, addr, reg2, wd, wreg, alu);
    dbus_rdata = rdata;
    dbus_ack   = 1'($urandom_range(0, 1));
    #1;
    check("idle_state", 32'(lsu_state), 32'd0);
    check("idle_req", 32'(dbus_req), 32'd0);
    check("idle_bus_err", 32'(bus_err), 32'd0);
    check("idle_wreg", 32'(mem_wreg), 32'd0);
    check("idle_whilo", 32'(mem_whilo), 32'd0);
    if (is_misaligned(op, addr)) begin
      check("misal_addr_err", 32'(addr_err), 32'd1);
      check("misal_stall", 32'(stallreq), 32'd0);
      @(negedge clk);
      set_inst(T_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      dbus_ack = 1'b0;
      #1;
      check("misal_err_pulse", 32'(addr_err), 32'd0);
      check("misal_state", 32'(lsu_state), 32'd0);
      check("misal_no_req", 32'(dbus_req), 32'd0);
      return;
    end
    check("idle_addr_err", 32'(addr_err), 32'd0);
    check("idle_stall", 32'(stallreq), 32'd1);
    timed = 1'b0;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      dbus_ack = (k == ack_after);
      #1;
      check("wait_state", 32'(lsu_state), 32'd1);
      check("wait_req", 32'(dbus_req), 32'd1);
      check("wait_stall", 32'(stallreq), 32'd1);
      check("wait_wreg", 32'(mem_wreg), 32'd0);
      check("wait_bus_err", 32'(bus_err), 32'd0);
      check("wait_addr", dbus_addr, {addr[31:2], 2'b00});
      check("wait_we", 32'(dbus_we), is_load(op) ? 32'd0 : 32'd1);
      if (!is_load(op)) begin
        check("wait_sel", 32'(dbus_sel), 32'(model_sel(op, addr)));
        check("wait_wdata", dbus_wdata, model_store(op, reg2));
      end
      if (dbus_ack) break;
      if (k == TO) begin
        timed = 1'b1;
        break;
      end
      if (k == TO + 1) check("wait_bound", 32'd1, 32'd0);
    end
    @(negedge clk);
    dbus_ack = 1'($urandom_range(0, 1));
    #1;
    exp_dw = exp_q.pop_front();
    check("done_state", 32'(lsu_state), 32'd2);
    check("done_stall", 32'(stallreq), 32'd0);
    check("done_req", 32'(dbus_req), 32'd0);
    check("done_bus_err", 32'(bus_err), timed ? 32'd1 : 32'd0);
    check("done_wd", 32'(mem_wd), 32'(wd));
    check("done_wreg", 32'(mem_wreg), (timed || !wreg) ? 32'd0 : 32'd1);
    check("done_whilo", 32'(mem_whilo), 32'd0);
    if (!(timed && is_load(op))) check("done_wdata", mem_wdata, exp_dw);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ops[9];
    logic [7:0]  op;
    logic [31:0] addr, reg2, rdata, alu;
    logic        wreg;
    int          ack_after;

    ops = '{T_LB, T_LBU, T_LH, T_LHU, T_LW, T_SB, T_SH, T_SW, T_ADD};

    // Reset with non-NOP inputs present
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'd0;
    set_inst(T_ADD, 32'h100, 32'h5, 5'd9, 1'b1, 32'hDEAD_BEEF);
    mem_hi_i = 32'h1111_2222;
    mem_lo_i = 32'h3333_4444;
    mem_whilo_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wd", 32'(mem_wd), 32'd0);
    check("rst_wreg", 32'(mem_wreg), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hi", mem_hi, 32'd0);
    check("rst_lo", mem_lo, 32'd0);
    check("rst_whilo", 32'(mem_whilo), 32'd0);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_state", 32'(lsu_state), 32'd0);
    rst = 1'b0;

    // ADD passthrough, several cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_inst(T_ADD, $urandom, $urandom, 5'd5, 1'b1, 32'h1234 + 32'(i));
      #1;
      check("add_wd", 32'(mem_wd), 32'd5);
      check("add_wreg", 32'(mem_wreg), 32'd1);
      check("add_wdata", mem_wdata, 32'h1234 + 32'(i));
      check("add_hi", mem_hi, mem_hi_i);
      check("add_lo", mem_lo, mem_lo_i);
      check("add_whilo", 32'(mem_whilo), 32'(mem_whilo_i));
      check("add_stall", 32'(stallreq), 32'd0);
      check("add_req", 32'(dbus_req), 32'd0);
    end

    // LB / LBU at 0x101, ack on third WAIT_ACK cycle
    exp_q.push_back(32'hFFFF_FF80);
    do_access(T_LB, 32'h101, 32'd0, 5'd3, 1'b1, 32'h101, 32'h1180_3344, 3);
    exp_q.push_back(32'h0000_0080);
    do_access(T_LBU, 32'h101, 32'd0, 5'd4, 1'b1, 32'h101, 32'h1180_3344, 3);

    // SH at 0x202: lanes 0011, replicated data, no register write
    exp_q.push_back(32'h202);
    do_access(T_SH, 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 32'h202, 32'd0, 2);

    // Misaligned LW
    do_access(T_LW, 32'h6, 32'd0, 5'd8, 1'b1, 32'h6, 32'd0, 1);

    // LW with no ack: times out after TO cycles
    exp_q.push_back(32'd0);
    do_access(T_LW, 32'h40, 32'd0, 5'd6, 1'b1, 32'h40, 32'd0, 0);

    // Reset in the second WAIT_ACK cycle
    @(negedge clk);
    set_inst(T_LW, 32'h80, 32'd0, 5'd7, 1'b1, 32'h80);
    dbus_ack = 1'b0;
    #1;
    check("rmid_idle_stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    #1;
    check("rmid_wait1_req", 32'(dbus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmid_req", 32'(dbus_req), 32'd0);
    check("rmid_stall", 32'(stallreq), 32'd0);
    check("rmid_wd", 32'(mem_wd), 32'd0);
    check("rmid_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_inst(T_ADD, 32'd0, 32'd0, 5'd7, 1'b1, 32'h77);
    dbus_ack = 1'b1;
    #1;
    check("rmid_after_state", 32'(lsu_state), 32'd0);
    check("rmid_after_req", 32'(dbus_req), 32'd0);
    check("rmid_after_stall", 32'(stallreq), 32'd0);
    check("rmid_after_wreg", 32'(mem_wreg), 32'd1);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    check("rmid_late_ack_state", 32'(lsu_state), 32'd0);
    check("rmid_late_ack_req", 32'(dbus_req), 32'd0);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      op    = ops[$urandom_range(0, 8)];
      addr  = $urandom;
      reg2  = $urandom;
      rdata = $urandom;
      alu   = $urandom;
      wreg  = 1'($urandom_range(0, 1));
      ack_after = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      if (op == T_ADD) begin
        @(negedge clk);
        set_inst(op, addr, reg2, 5'(i), wreg, alu);
        dbus_ack = 1'($urandom_range(0, 1));
        #1;
        check("rnd_pass_wdata", mem_wdata, alu);
        check("rnd_pass_wreg", 32'(mem_wreg), 32'(wreg));
        check("rnd_pass_stall", 32'(stallreq), 32'd0);
        check("rnd_pass_req", 32'(dbus_req), 32'd0);
      end else begin
        if (!is_misaligned(op, addr))
          exp_q.push_back(is_load(op) ? model_load(op, addr, rdata) : alu);
        do_access(op, addr, reg2, 5'(i), wreg, alu, rdata, ack_after);
      end
    end

    @(negedge clk);
    dbus_ack = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
